// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes and the "no register" marker.
package y86_pkg;

   typedef enum logic [3:0] {
      HALT   = 4'h0,
      NOP    = 4'h1,
      CMOVXX = 4'h2,
      IRMOVQ = 4'h3,
      RMMOVQ = 4'h4,
      MRMOVQ = 4'h5,
      OPQ    = 4'h6,
      JXX    = 4'h7,
      CALL   = 4'h8,
      RET    = 4'h9,
      PUSHQ  = 4'hA,
      POPQ   = 4'hB
   } icode_e;

   typedef enum logic [2:0] {
      AOK = 3'd1,
      HLT = 3'd2,
      ADR = 3'd3,
      INS = 3'd4
   } stat_e;

   localparam logic [3:0] RNONE = 4'hF;

   // Instructions that read a quadword from data memory.
   function automatic logic is_mem_rd(input logic [3:0] icode);
      return (icode == MRMOVQ) || (icode == RET) || (icode == POPQ);
   endfunction

   // Instructions that write a quadword to data memory.
   function automatic logic is_mem_wr(input logic [3:0] icode);
      return (icode == RMMOVQ) || (icode == CALL) || (icode == PUSHQ);
   endfunction

endpackage

// File: rtl/memory_stage_data_mem.sv
// Byte-addressed data memory: 8-byte little-endian combinational read,
// 8-byte synchronous write, and a single-byte backdoor write port.
module data_mem #(
   parameter int MEM_BYTES = 1024,
   parameter int ADDR_W    = 10
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [63:0]       rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [63:0]       wr_data,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_data
);

   logic [7:0] mem [MEM_BYTES];

   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         rd_data[8*i +: 8] = mem[rd_addr + ADDR_W'(i)];
      end
   end

   // The backdoor assignment comes last so it overrides a colliding pipeline byte.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned i = 0; i < 8; i++) begin
            mem[wr_addr + ADDR_W'(i)] <= wr_data[8*i +: 8];
         end
      end
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end
   end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: access decode, address check, exception lock,
// data memory and the M->W pipeline register.
module memory_stage
   import y86_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int ADDR_W    = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m_stall,
   input  logic              m_bubble,
   input  logic [3:0]        icode_in,
   input  logic              cnd_in,
   input  logic [2:0]        stat_in,
   input  logic [63:0]       valE_in,
   input  logic [63:0]       valA_in,
   input  logic [63:0]       valP_in,
   input  logic [3:0]        dstE_in,
   input  logic [3:0]        dstM_in,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_data,
   output logic [63:0]       m_valM,
   output logic [2:0]        m_stat,
   output logic [2:0]        w_stat,
   output logic [3:0]        w_icode,
   output logic              w_cnd,
   output logic [63:0]       w_valE,
   output logic [63:0]       w_valM,
   output logic [3:0]        w_dstE,
   output logic [3:0]        w_dstM
);

   logic        rd;
   logic        wr;
   logic        addr_err;
   logic        wr_en;
   logic        lock;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [63:0] rd_data;

   always_comb begin
      rd       = is_mem_rd(icode_in);
      wr       = is_mem_wr(icode_in);
      addr     = ((icode_in == RET) || (icode_in == POPQ)) ? valA_in : valE_in;
      wdata    = (icode_in == CALL) ? valP_in : valA_in;
      addr_err = (rd || wr) && (addr > 64'(MEM_BYTES - 8));
      m_valM   = (rd && !addr_err) ? rd_data : '0;
      m_stat   = addr_err ? 3'(ADR) : stat_in;
      // rst_n gating drops any store that would land on an edge seen during reset.
      wr_en    = rst_n && wr && !addr_err && (stat_in == 3'(AOK))
                 && !m_stall && !m_bubble && !lock;
   end

   data_mem #(
      .MEM_BYTES (MEM_BYTES),
      .ADDR_W    (ADDR_W)
   ) u_data_mem (
      .clk     (clk),
      .rd_addr (addr[ADDR_W-1:0]),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_addr (addr[ADDR_W-1:0]),
      .wr_data (wdata),
      .ld_en   (ld_en),
      .ld_addr (ld_addr),
      .ld_data (ld_data)
   );

   // lock rises on the same edge that registers a non-AOK status into W,
   // so nothing after the faulting instruction can store.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_stat  <= 3'(AOK);
         w_icode <= 4'(NOP);
         w_cnd   <= 1'b0;
         w_valE  <= '0;
         w_valM  <= '0;
         w_dstE  <= RNONE;
         w_dstM  <= RNONE;
         lock    <= 1'b0;
      end else if (m_bubble) begin
         w_stat  <= 3'(AOK);
         w_icode <= 4'(NOP);
         w_cnd   <= 1'b0;
         w_valE  <= '0;
         w_valM  <= '0;
         w_dstE  <= RNONE;
         w_dstM  <= RNONE;
      end else if (!m_stall) begin
         w_stat  <= m_stat;
         w_icode <= icode_in;
         w_cnd   <= cnd_in;
         w_valE  <= valE_in;
         w_valM  <= m_valM;
         w_dstE  <= dstE_in;
         w_dstM  <= dstM_in;
         if (m_stat != 3'(AOK)) begin
            lock <= 1'b1;
         end
      end
   end

endmodule
